ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000: clk cycles the PS2 clock is held low before the start bit (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000: maximum clk cycles between consecutive expected device clock falling edges (20 ms at 100 MHz).
REQ-003 Parameter FILTER_LEN, default 8: consecutive equal synchronized samples required to accept a new level on ps2_clk_in.
REQ-004 clk  in  1  system clock, 100 MHz domain; the only clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 tx_data  in  8  command byte to send to the device (e.g. 0xED set-LEDs).
REQ-007 tx_valid  in  1  request; the byte is accepted in a cycle where tx_valid and tx_ready are both 1.
REQ-008 tx_ready  out  1  high only in IDLE.
REQ-009 ps2_clk_in / ps2_data_in  in  1 each  raw PS2 line levels (asynchronous).
REQ-010 ps2_clk_oe / ps2_data_oe  out  1 each  1 = drive line low, 0 = release (open drain, pull-up external).
REQ-011 busy  out  1  high in every state except IDLE; the top level uses it to gate the existing keyboard receiver.
REQ-012 done / ack_err / timeout_err  out  1 each  single-cycle completion pulses, mutually exclusive.

Function
REQ-013 Both line inputs SHALL pass a 2-FF synchronizer; ps2_clk additionally passes the FILTER_LEN glitch filter. A falling edge is the filtered level changing 1->0.
REQ-014 FSM states: IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-015 IDLE: on handshake, latch tx_data into a shift register, compute the odd parity bit (parity = ~^tx_data), and go to INHIBIT.
REQ-016 INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles. ps2_data_oe rises to 1 during the final cycle of INHIBIT (start bit). Then go to REQ.
REQ-017 REQ: ps2_clk_oe = 0 and ps2_data_oe = 1. On the first falling edge, drive bit0 (data_oe = ~bit) and go to DATA.
REQ-018 DATA: on each falling edge, shift out the next bit LSB first. A 3-bit counter tracks the bits. On the falling edge after bit7 is presented, drive parity and go to PARITY.
REQ-019 PARITY: on the next falling edge, release data (stop bit = 1) and go to STOP.
REQ-020 STOP: on the next falling edge, sample synchronized ps2_data_in. Sampled 0 -> ACK. Sampled 1 -> pulse ack_err and go to WAIT_IDLE.
REQ-021 ACK: go to WAIT_IDLE. done is pulsed once both filtered clock and synchronized data are high.
REQ-022 WAIT_IDLE: stay until filtered clock and synchronized data are both high for one cycle, then go to IDLE.
REQ-023 The timeout counter reloads on every falling edge and on entry to REQ. If it reaches TIMEOUT_CYCLES in REQ, DATA, PARITY, STOP or WAIT_IDLE, pulse timeout_err, release both lines and go to IDLE.
REQ-024 Exactly one of done, ack_err or timeout_err is pulsed per accepted byte. ack_err may precede the return to IDLE.
REQ-025 tx_valid is ignored while busy; there is no queueing.
REQ-026 Falling edges seen in IDLE or INHIBIT are ignored and do not affect state.

Reset
REQ-027 rst asynchronously forces IDLE and clears the counters and shift register.
REQ-028 rst asynchronously forces ps2_clk_oe = ps2_data_oe = 0, busy = 0, tx_ready = 1, and all pulses to 0.
REQ-029 Reset mid-transfer SHALL release both lines in the same cycle. No done, ack_err or timeout_err follows.

Structure
REQ-030 A shared ps2_pkg SHALL hold the state enum and the command constants CMD_SET_LEDS = 0xED, CMD_ENABLE = 0xF4 and CMD_RESET = 0xFF.
REQ-031 The synchronizer plus glitch filter SHALL be one sub-module, ps2_line_filter, instantiated once per line (data with FILTER_LEN = 1), so it can be reused by the receiver path.

Verification (scaled parameters: INHIBIT_CYCLES = 20, TIMEOUT_CYCLES = 500, FILTER_LEN = 4; device BFM with a 40-clk half period)
REQ-032 Send 0xED with the BFM acking. Required: clock held low exactly 20 cycles; the BFM reads start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; tx_ready returns to 1.
REQ-033 Send 0xF4 with the BFM not acking (data high on the 11th clock). Required: parity observed = 0; one ack_err pulse; no done.
REQ-034 The BFM never clocks after the request. Required: timeout_err at 500 cycles after REQ entry; both oe = 0; state IDLE.
REQ-035 Assert rst during DATA bit 4. Required: ps2_clk_oe = ps2_data_oe = 0 in the same cycle; no completion pulse; a following 0xFF transfer completes with done and parity 1.
REQ-036 Inject 2-cycle glitches on ps2_clk during DATA, plus tx_valid pulses while busy. Required: no extra bits shifted, the byte is received intact, and the second request is not accepted.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common device commands
// and the odd-parity helper used by both transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // PS/2 frames carry odd parity over the data byte
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Brings one raw PS/2 line into the clk domain: 2-FF synchronizer followed by
// a level filter that needs FILTER_LEN consecutive equal samples to switch.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Lines idle high, so reset to 1 avoids a fake edge out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], line};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts a command byte out on device clock falls and checks the device ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  ps2_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          done_n, ack_err_n, timeout_n;
  logic          clk_lvl, clk_prev, clk_fall, dat_lvl;
  logic          inh_last, tmo;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .line(ps2_clk_in), .level(clk_lvl)
  );

  ps2_line_filter #(.FILTER_LEN(1)) u_dat_filt (
    .clk(clk), .rst(rst), .line(ps2_data_in), .level(dat_lvl)
  );

  assign clk_fall = clk_prev & ~clk_lvl;
  assign inh_last = (cnt == CW'(INHIBIT_CYCLES - 1));
  assign tmo      = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      bit_cnt     <= '0;
      clk_prev    <= 1'b1;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      par         <= par_n;
      bit_cnt     <= bit_cnt_n;
      clk_prev    <= clk_lvl;
      done        <= done_n;
      ack_err     <= ack_err_n;
      timeout_err <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    par_n     = par;
    bit_cnt_n = bit_cnt;
    done_n    = 1'b0;
    ack_err_n = 1'b0;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          shreg_n   = tx_data;
          par_n     = odd_parity(tx_data);
          bit_cnt_n = '0;
          cnt_n     = '0;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_last) begin
          cnt_n   = '0;
          state_n = REQ;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ACK: begin
        if (clk_lvl && dat_lvl) begin
          done_n  = 1'b1;
          state_n = WAIT_IDLE;
        end
      end
      default: begin
        cnt_n = clk_fall ? '0 : cnt + CW'(1);
        if (clk_fall) begin
          unique case (state)
            REQ:    state_n = DATA;
            DATA: begin
              if (bit_cnt == 3'd7) begin
                state_n = PARITY;
              end else begin
                shreg_n   = {1'b0, shreg[7:1]};
                bit_cnt_n = bit_cnt + 3'd1;
              end
            end
            PARITY: state_n = STOP;
            STOP: begin
              if (dat_lvl) begin
                ack_err_n = 1'b1;
                state_n   = WAIT_IDLE;
              end else begin
                state_n = ACK;
              end
            end
            default: ;
          endcase
        end else if (tmo) begin
          // WAIT_IDLE is only reached after done/ack_err, so stay silent there
          timeout_n = (state != WAIT_IDLE);
          cnt_n     = '0;
          state_n   = IDLE;
        end else if (state == WAIT_IDLE && clk_lvl && dat_lvl) begin
          state_n = IDLE;
        end
      end
    endcase
  end

  // Line drives decode straight from state so reset releases them immediately
  always_comb begin
    ps2_data_oe = 1'b0;
    unique case (state)
      INHIBIT: ps2_data_oe = inh_last;
      REQ:     ps2_data_oe = 1'b1;
      DATA:    ps2_data_oe = ~shreg[0];
      PARITY:  ps2_data_oe = ~par;
      default: ps2_data_oe = 1'b0;
    endcase
  end

  assign ps2_clk_oe = (state == INHIBIT);
  assign busy       = (state != IDLE);
  assign tx_ready   = (state == IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device BFM clocks frames out of the host, a frame
// model built from the byte checks them, and a per-cycle monitor checks outputs.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
  logic       bfm_clk, bfm_dat;
  logic       ps2_clk_in, ps2_data_in;

  int checks = 0, failures = 0;
  int n_done = 0, n_ackerr = 0, n_tmo = 0;
  int run = 0, dat_first = 0, inh_len = 0, inh_dat = 0;
  logic [10:0] rd;

  always #5 clk = ~clk;

  assign ps2_clk_in  = bfm_clk & ~ps2_clk_oe;
  assign ps2_data_in = bfm_dat & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as the device sees it: start, data LSB first, odd parity, stop
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2 == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (done)        n_done   <= n_done + 1;
    if (ack_err)     n_ackerr <= n_ackerr + 1;
    if (timeout_err) n_tmo    <= n_tmo + 1;
  end

  // Length of each clock-inhibit window and where the start bit appears in it
  always @(negedge clk) begin
    if (ps2_clk_oe) begin
      run <= run + 1;
      if (ps2_data_oe && dat_first == 0) dat_first <= run + 1;
    end else begin
      if (run != 0) begin
        inh_len <= run;
        inh_dat <= dat_first;
      end
      run       <= 0;
      dat_first <= 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_vs_busy", tx_ready, !busy);
      chk("pulse_onehot", (int'(done) + int'(ack_err) + int'(timeout_err)) <= 1, 1);
      if (!busy) chk("idle_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("accepted", busy, 1);
  endtask

  task automatic bfm_xfer(input bit ack, input bit glitch, input int abort_k, output logic [10:0] f);
    int n;
    f = '0;
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", n < 300, 1);
    if (n >= 300) return;
    repeat (40) @(negedge clk);
    f[0] = ps2_data_in;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) begin
        bfm_dat = 1'b0;
        repeat (5) @(negedge clk);
      end
      bfm_clk = 1'b0;
      if (k == abort_k) begin
        repeat (20) @(negedge clk);
        return;
      end
      repeat (40) @(negedge clk);
      if (k <= 10) f[k] = ps2_data_in;
      bfm_clk = 1'b1;
      if (k == 11) bfm_dat = 1'b1;
      if (glitch && k >= 2 && k <= 8) begin
        repeat (15) @(negedge clk);
        bfm_clk = 1'b0;
        repeat (2) @(negedge clk);
        bfm_clk = 1'b1;
        repeat (23) @(negedge clk);
      end else begin
        repeat (40) @(negedge clk);
      end
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack, input bit glitch, output logic [10:0] f);
    int d0, a0, t0, n;
    d0 = n_done; a0 = n_ackerr; t0 = n_tmo;
    send(b);
    bfm_xfer(ack, glitch, 0, f);
    n = 0;
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("frame", f, exp_frame(b));
    chk("inhibit_len", inh_len, INH);
    chk("start_bit_cycle", inh_dat, INH);
    chk("done_count", n_done - d0, ack);
    chk("ack_err_count", n_ackerr - a0, !ack);
    chk("timeout_count", n_tmo - t0, 0);
    chk("ready_after", tx_ready, 1);
  endtask

  initial begin
    int d0, a0, t0, n, seen;
    logic [7:0] rb;
    bit ra, rg;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; bfm_clk = 1'b1; bfm_dat = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("rst_pulses", {done, ack_err, timeout_err}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Set-LEDs with ack
    xfer(CMD_SET_LEDS, 1'b1, 1'b0, rd);
    chk("ed_frame_literal", rd, 11'b11111011010);

    // Enable without ack
    xfer(CMD_ENABLE, 1'b0, 1'b0, rd);
    chk("f4_parity_literal", rd[9], 0);

    // Device never clocks
    d0 = n_done; a0 = n_ackerr; t0 = n_tmo;
    send(CMD_ENABLE);
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_req_seen", n < 300, 1);
    n = 0;
    while (!timeout_err && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycle", n, TMO);
    chk("tmo_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("tmo_idle", tx_ready, 1);
    repeat (5) @(negedge clk);
    chk("tmo_count", n_tmo - t0, 1);
    chk("tmo_no_done", (n_done - d0) + (n_ackerr - a0), 0);

    // Reset while bit 4 (a 0 in 0xED) is on the line
    d0 = n_done; a0 = n_ackerr; t0 = n_tmo;
    send(CMD_SET_LEDS);
    bfm_xfer(1'b1, 1'b0, 5, rd);
    chk("bit4_driven", ps2_data_oe, 1);
    chk("bit4_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_clk_oe", ps2_clk_oe, 0);
    chk("rst_mid_data_oe", ps2_data_oe, 0);
    bfm_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_no_pulse", (n_done - d0) + (n_ackerr - a0) + (n_tmo - t0), 0);
    xfer(CMD_RESET, 1'b1, 1'b0, rd);
    chk("ff_parity_literal", rd[9], 1);

    // Clock glitches plus requests while busy
    fork
      xfer(8'h3C, 1'b1, 1'b1, rd);
      begin
        repeat (60) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          if (busy) begin
            tx_data  = 8'hA5;
            tx_valid = 1'b1;
          end
          @(negedge clk);
          tx_valid = 1'b0;
          repeat (100) @(negedge clk);
        end
      end
    join
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("no_second_accept", seen, 0);

    // Random bytes, ack and glitch choices
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      rg = 1'($urandom_range(0, 1));
      xfer(rb, ra, rg, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
